// File: rtl/memory_sequencer_if.sv
// Memory and ALU bus between the accumulator-machine sequencer and its
// external synchronous memory and combinational ALU.
interface memory_sequencer_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  modport master (
    output mem_addr, mem_wdata, mem_we, alu_opcode, alu_a, alu_b,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, alu_opcode, alu_a, alu_b,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/memory_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator machine. Holds PC, IR
// and AC, initiates all memory cycles and borrows the external ALU for
// ADD/SUBT. Bus outputs are decoded from the current state only.
module memory_sequencer #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  memory_sequencer_if.master  bus,
  output logic [ADDR_W-1:0]   pc,
  output logic [15:0]         ir,
  output logic [15:0]         ac,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_OPER_WAIT, S_OPER_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       ac_q, ac_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] opx;
  logic [ADDR_W-1:0] addr;
  logic signed [15:0] ac_s;
  logic              skip;

  assign opcode = ir_q[15:12];
  assign opx    = ir_q[ADDR_W-1:0];
  assign ac_s   = ac_q;

  // SKIPCOND condition on the signed accumulator; code 11 never skips.
  always_comb begin
    skip = 1'b0;
    case (ir_q[11:10])
      2'b00:   skip = (ac_s < 0);
      2'b01:   skip = (ac_s == 0);
      2'b10:   skip = (ac_s > 0);
      default: skip = 1'b0;
    endcase
  end

  // Architectural state; async reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      ac_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ac_q      <= ac_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, register updates and state-decoded bus controls.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    ac_d           = ac_q;
    illegal_d      = illegal_q;
    addr           = '0;
    bus.mem_we     = 1'b0;
    bus.alu_opcode = ALU_ADD;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        addr    = pc_q;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        addr    = pc_q;
        ir_d    = bus.mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        addr    = opx;
        state_d = S_FETCH;
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT: state_d = S_OPER_WAIT;
          OP_STORE: bus.mem_we = 1'b1;
          OP_JUMP:  pc_d = opx;
          OP_CLEAR: ac_d = '0;
          OP_SKIP:  if (skip) pc_d = pc_q + 1'b1;
          OP_HALT:  state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_OPER_WAIT: begin
        addr    = opx;
        state_d = S_FETCH;
        if (opcode == OP_SUBT) bus.alu_opcode = ALU_SUB;
        if (opcode == OP_LOAD) ac_d = bus.mem_rdata;
        else                   ac_d = bus.alu_result;
      end
      S_OPER_WB: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Zero-extend the internal address onto the 16-bit memory bus.
  always_comb begin
    bus.mem_addr             = '0;
    bus.mem_addr[ADDR_W-1:0] = addr;
  end

  assign bus.mem_wdata = ac_q;
  assign bus.alu_a     = ac_q;
  assign bus.alu_b     = bus.mem_rdata;

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign ac      = ac_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: synchronous memory and ALU models, directed
// programs from the test plan, and random programs checked against an
// instruction-level model of the machine.
module tb_memory_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [11:0] pc;
  logic [15:0] ir, ac;
  logic        halted, illegal;

  memory_sequencer_if bus();

  memory_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus),
    .pc(pc), .ir(ir), .ac(ac), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] img [0:4095];
  logic [15:0] mem [0:4095];
  logic        ld_all = 1'b0;
  int          we_count = 0;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[11:0]];
  end

  assign bus.alu_result = (bus.alu_opcode == 4'h1) ? bus.alu_a - bus.alu_b
                                                   : bus.alu_a + bus.alu_b;

  always @(negedge clk) if (bus.mem_we === 1'b1) we_count++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input logic [15:0] v);
    for (int i = 0; i < 4096; i++) img[i] = v;
  endtask

  // Reset, load img into memory, release reset and raise run; returns
  // just after the IDLE->FETCH edge.
  task automatic start_prog();
    reset = 1'b1;
    run   = 1'b0;
    ld_all = 1'b1;
    step(1);
    ld_all = 1'b0;
    step(1);
    reset = 1'b0;
    run   = 1'b1;
    step(1);
  endtask

  task automatic run_until_halt(input int limit, output int n);
    n = 0;
    while (!halted && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    assert (halted === 1'b1) else begin
      failures++;
      $error("FAIL halt_timeout observed=%0d expected=halted within %0d", n, limit);
    end
  endtask

  // Instruction-level reference model.
  logic [15:0] m_mem [0:4095];
  logic [11:0] m_pc;
  logic [15:0] m_ac, m_ir;
  logic        m_halt, m_ill;
  int          m_stores;

  task automatic model_run(input int max_instr, output int cycles);
    logic [15:0] w;
    logic [11:0] x;
    logic signed [15:0] sac;
    bit take;
    cycles = 0;
    m_stores = 0;
    for (int i = 0; i < 4096; i++) m_mem[i] = img[i];
    m_pc = 12'h000; m_ac = 16'h0; m_ir = 16'h0; m_halt = 0; m_ill = 0;
    for (int k = 0; k < max_instr && !m_halt; k++) begin
      w = m_mem[m_pc];
      m_ir = w;
      m_pc = m_pc + 12'd1;
      x = w[11:0];
      case (w[15:12])
        4'h1: begin m_ac = m_mem[x]; cycles += 4; end
        4'h2: begin m_mem[x] = m_ac; m_stores++; cycles += 3; end
        4'h3: begin m_ac = m_ac + m_mem[x]; cycles += 4; end
        4'h4: begin m_ac = m_ac - m_mem[x]; cycles += 4; end
        4'h7: begin m_halt = 1; cycles += 3; end
        4'h8: begin
          sac = m_ac;
          case (w[11:10])
            2'b00:   take = (sac < 0);
            2'b01:   take = (sac == 0);
            2'b10:   take = (sac > 0);
            default: take = 0;
          endcase
          if (take) m_pc = m_pc + 12'd1;
          cycles += 3;
        end
        4'h9: begin m_pc = x; cycles += 3; end
        4'hA: begin m_ac = 16'h0; cycles += 3; end
        default: begin m_ill = 1; m_halt = 1; cycles += 3; end
      endcase
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    int sel;
    sel = $urandom_range(0, 19);
    if (sel < 3)       w = {4'h1, 12'($urandom_range(32, 63))};
    else if (sel < 6)  w = {4'h2, 12'($urandom_range(32, 63))};
    else if (sel < 9)  w = {4'h3, 12'($urandom_range(32, 63))};
    else if (sel < 12) w = {4'h4, 12'($urandom_range(32, 63))};
    else if (sel < 15) w = {4'h8, 2'($urandom_range(0, 3)), 10'($urandom)};
    else if (sel < 17) w = {4'h9, 12'($urandom_range(0, 23))};
    else if (sel < 19) w = {4'hA, 12'($urandom)};
    else               w = {4'hB, 12'($urandom)};
    return w;
  endfunction

  initial begin
    int n, cyc, we0;

    // Reset values
    fill_img(16'h7000);
    reset = 1'b1;
    step(2);
    check("rst_pc", {4'h0, pc}, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_ac", ac, 16'h0000);
    check("rst_halted", {15'h0, halted}, 16'h0000);
    check("rst_illegal", {15'h0, illegal}, 16'h0000);
    check("rst_we", {15'h0, bus.mem_we}, 16'h0000);
    check("rst_addr", bus.mem_addr, 16'h0000);

    // LOAD/ADD/STORE/HALT; n counts the IDLE->FETCH edge plus 4+4+3+3
    fill_img(16'h7000);
    img[0] = 16'h1004; img[1] = 16'h3005; img[2] = 16'h2006; img[3] = 16'h7000;
    img[4] = 16'h0010; img[5] = 16'h0022;
    start_prog();
    n = 1;
    begin
      int m;
      run_until_halt(40, m);
      n += m;
    end
    check("las_cycles", 16'(n), 16'd15);
    check("las_mem6", mem[6], 16'h0032);
    check("las_ac", ac, 16'h0032);
    check("las_pc", {4'h0, pc}, 16'h0004);
    check("las_halted", {15'h0, halted}, 16'h0001);
    check("las_halt_addr", bus.mem_addr, 16'h0000);

    // SUBT wrap then SKIPCOND on negative AC skips the JUMP
    fill_img(16'h7000);
    img[0] = 16'h1010; img[1] = 16'h4011; img[2] = 16'h8000; img[3] = 16'h9000;
    img[4] = 16'h7000; img[16'h10] = 16'h0001; img[16'h11] = 16'h0003;
    start_prog();
    run_until_halt(60, n);
    check("subt_ac", ac, 16'hFFFE);
    check("subt_pc", {4'h0, pc}, 16'h0005);

    // SKIPCOND matrix
    fill_img(16'h7000);
    img[0] = 16'hA000; img[1] = 16'h8400; img[2] = 16'h7000; img[3] = 16'h1010;
    img[4] = 16'h8800; img[5] = 16'h7000; img[6] = 16'h8000; img[7] = 16'h3012;
    img[8] = 16'h8C00; img[9] = 16'h3012; img[10] = 16'h7000;
    img[16'h10] = 16'h0005; img[16'h12] = 16'h0001;
    start_prog();
    run_until_halt(80, n);
    check("skip_ac", ac, 16'h0007);
    check("skip_pc", {4'h0, pc}, 16'h000B);

    // JUMP to 0xFFF, CLEAR there, PC wraps to 0
    fill_img(16'h7000);
    img[0] = 16'h1010; img[1] = 16'h9FFF; img[12'hFFF] = 16'hA000;
    img[16'h10] = 16'h1234;
    start_prog();
    step(4);
    check("jmp_load_ac", ac, 16'h1234);
    step(3);
    check("jmp_pc", {4'h0, pc}, 16'h0FFF);
    step(3);
    check("wrap_ac", ac, 16'h0000);
    check("wrap_pc", {4'h0, pc}, 16'h0000);
    check("wrap_fetch_addr", bus.mem_addr, 16'h0000);

    // Illegal opcode
    fill_img(16'h7000);
    img[0] = 16'hF123;
    we0 = we_count;
    start_prog();
    step(3);
    check("ill_illegal", {15'h0, illegal}, 16'h0001);
    check("ill_halted", {15'h0, halted}, 16'h0001);
    run = 1'b0; step(2); run = 1'b1; step(2); run = 1'b0; step(1);
    check("ill_still_halted", {15'h0, halted}, 16'h0001);
    check("ill_sticky", {15'h0, illegal}, 16'h0001);
    check("ill_pc", {4'h0, pc}, 16'h0001);
    check("ill_no_we", 16'(we_count - we0), 16'h0000);

    // Reset during STORE's DECODE cycle
    fill_img(16'h7000);
    img[0] = 16'h1010; img[1] = 16'h2020; img[16'h10] = 16'hBEEF;
    img[16'h20] = 16'h5555;
    start_prog();
    step(4 + 2);
    check("st_we_before_rst", {15'h0, bus.mem_we}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("st_rst_we", {15'h0, bus.mem_we}, 16'h0000);
    check("st_rst_pc", {4'h0, pc}, 16'h0000);
    check("st_rst_ac", ac, 16'h0000);
    check("st_rst_ir", ir, 16'h0000);
    check("st_rst_addr", bus.mem_addr, 16'h0000);
    step(2);
    check("st_rst_mem", mem[16'h20], 16'h5555);
    check("st_rst_halted", {15'h0, halted}, 16'h0000);

    // Random programs against the instruction-level model
    for (int t = 0; t < 6; t++) begin
      fill_img(16'h7000);
      for (int i = 0; i < 24; i++) img[i] = rand_instr();
      for (int i = 32; i < 64; i++) img[i] = 16'($urandom);
      model_run(60, cyc);
      we0 = we_count;
      start_prog();
      step(cyc);
      check($sformatf("rnd%0d_pc", t), {4'h0, pc}, {4'h0, m_pc});
      check($sformatf("rnd%0d_ac", t), ac, m_ac);
      check($sformatf("rnd%0d_ir", t), ir, m_ir);
      check($sformatf("rnd%0d_halted", t), {15'h0, halted}, {15'h0, m_halt});
      check($sformatf("rnd%0d_illegal", t), {15'h0, illegal}, {15'h0, m_ill});
      check($sformatf("rnd%0d_stores", t), 16'(we_count - we0), 16'(m_stores));
      for (int i = 0; i < 64; i++)
        check($sformatf("rnd%0d_mem%0d", t, i), mem[i], m_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
